// File: rtl/bsg_manycore_edge_pkg.sv
// Shared types for the edge memory responder: opcodes, packet layout and a
// saturating counter helper.
`ifndef BSG_MANYCORE_EDGE_PKG_SV
`define BSG_MANYCORE_EDGE_PKG_SV

// Packet layout, MSB first: {op, mask, addr, data, y_cord, x_cord}
`define BSG_MANYCORE_EDGE_PACKET_S(dw, aw, yw, xw) \
  struct packed { \
    logic [1:0]          op; \
    logic [(dw)/8-1:0]   mask; \
    logic [(aw)-1:0]     addr; \
    logic [(dw)-1:0]     data; \
    logic [(yw)-1:0]     y_cord; \
    logic [(xw)-1:0]     x_cord; \
  }

package bsg_manycore_edge_pkg;

  typedef enum logic [1:0] {
    STORE = 2'b01,
    LOAD  = 2'b10
  } op_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with valid/ready enqueue and valid/yumi dequeue.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2,
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rd_ptr, wr_ptr;
  logic [ptr_w_lp:0]   count;
  logic                enq;

  assign enq     = v_i & ready_o;
  assign ready_o = (count != (ptr_w_lp+1)'(els_p));
  assign v_o     = (count != '0);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)
        wr_ptr <= (wr_ptr == ptr_w_lp'(els_p-1)) ? '0 : wr_ptr + 1'b1;
      if (yumi_i)
        rd_ptr <= (rd_ptr == ptr_w_lp'(els_p-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + (ptr_w_lp+1)'(enq) - (ptr_w_lp+1)'(yumi_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_edge_mem_responder_ram.sv
// Single-port synchronous RAM with byte-masked writes; read data is valid the
// cycle after a read access and holds until the next read.
module bsg_manycore_edge_mem_responder_ram #(
  parameter int width_p = 32,
  parameter int els_p   = 1024,
  localparam int addr_w_lp = $clog2(els_p),
  localparam int mask_w_lp = width_p/8
) (
  input  logic                 clk_i,
  input  logic                 v_i,
  input  logic                 w_i,
  input  logic [addr_w_lp-1:0] addr_i,
  input  logic [mask_w_lp-1:0] mask_i,
  input  logic [width_p-1:0]   data_i,
  output logic [width_p-1:0]   data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) begin
        for (int i = 0; i < mask_w_lp; i++)
          if (mask_i[i]) mem[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
      end else begin
        data_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_edge_mem_responder.sv
// Edge-port memory endpoint: executes stores into a local RAM and answers each
// load with a store-format reply packet sent back into the mesh.
module bsg_manycore_edge_mem_responder
  import bsg_manycore_edge_pkg::*;
#(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 14,
  parameter int x_cord_width_p = 2,
  parameter int y_cord_width_p = 3,
  parameter int mem_els_p      = 1024,
  parameter int fifo_els_p     = 2,
  localparam int packet_width_lp = 2 + (data_width_p/8) + addr_width_p + data_width_p
                                   + y_cord_width_p + x_cord_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [packet_width_lp-1:0] data_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [packet_width_lp-1:0] data_o,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic [31:0]                store_count_o,
  output logic [31:0]                load_count_o,
  output logic [15:0]                drop_count_o
);

  localparam int idx_w_lp = $clog2(mem_els_p);

  typedef `BSG_MANYCORE_EDGE_PACKET_S(data_width_p, addr_width_p, y_cord_width_p, x_cord_width_p) packet_s;

  // IDLE: pop and execute the FIFO head | RESP: hold reply until ready_i
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e                    state;
  packet_s                   req, rsp;
  logic                      head_v, pop, in_range, store_go, load_go, drop_go;
  logic [addr_width_p-1:0]   addr_q;
  logic [x_cord_width_p-1:0] ret_x;
  logic [y_cord_width_p-1:0] ret_y;
  logic [data_width_p-1:0]   ram_data;
  logic [31:0]               store_cnt, load_cnt;
  logic [15:0]               drop_cnt;

  bsg_fifo_1r1w_small #(.width_p(packet_width_lp), .els_p(fifo_els_p)) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (data_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_o    (req),
    .v_o       (head_v),
    .yumi_i    (pop)
  );

  assign pop      = head_v & (state == IDLE);
  assign in_range = ((req.addr >> idx_w_lp) == '0);
  assign store_go = pop & in_range & (req.op == STORE);
  assign load_go  = pop & in_range & (req.op == LOAD);
  assign drop_go  = pop & ~store_go & ~load_go;

  bsg_manycore_edge_mem_responder_ram #(.width_p(data_width_p), .els_p(mem_els_p)) ram (
    .clk_i  (clk_i),
    .v_i    (store_go | load_go),
    .w_i    (store_go),
    .addr_i (req.addr[idx_w_lp-1:0]),
    .mask_i (req.mask),
    .data_i (req.data),
    .data_o (ram_data)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      addr_q    <= '0;
      ret_x     <= '0;
      ret_y     <= '0;
      store_cnt <= '0;
      load_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (load_go) begin
          state  <= RESP;
          addr_q <= req.addr;
          ret_x  <= req.data[x_cord_width_p-1:0];
          ret_y  <= req.data[x_cord_width_p +: y_cord_width_p];
        end
        RESP: if (ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (store_go) store_cnt <= sat_inc(store_cnt, 32'hFFFF_FFFF);
      if (load_go)  load_cnt  <= sat_inc(load_cnt, 32'hFFFF_FFFF);
      if (drop_go)  drop_cnt  <= 16'(sat_inc({16'h0, drop_cnt}, 32'h0000_FFFF));
    end
  end

  // RAM output is untouched during RESP since nothing is popped, so the reply holds.
  always_comb begin
    rsp = '0;
    if (state == RESP) begin
      rsp.op     = STORE;
      rsp.mask   = '1;
      rsp.addr   = addr_q;
      rsp.data   = ram_data;
      rsp.y_cord = ret_y;
      rsp.x_cord = ret_x;
    end
  end

  assign data_o        = rsp;
  assign v_o           = (state == RESP);
  assign store_count_o = store_cnt;
  assign load_count_o  = load_cnt;
  assign drop_count_o  = drop_cnt;

endmodule

// File: tb/tb_bsg_manycore_edge_mem_responder.sv
// Scoreboard bench for the edge memory responder: expected replies are queued
// when loads are driven and compared when the DUT hands a reply off.
module tb_bsg_manycore_edge_mem_responder;

  localparam int PW = 57;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [PW-1:0] data_i;
  logic          v_i;
  logic          ready_o;
  logic [PW-1:0] data_o;
  logic          v_o;
  logic          ready_i;
  logic [31:0]   store_count_o, load_count_o;
  logic [15:0]   drop_count_o;

  bsg_manycore_edge_mem_responder dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .data_i        (data_i),
    .v_i           (v_i),
    .ready_o       (ready_o),
    .data_o        (data_o),
    .v_o           (v_o),
    .ready_i       (ready_i),
    .store_count_o (store_count_o),
    .load_count_o  (load_count_o),
    .drop_count_o  (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [31:0]   mdl [1024];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [1:0] op, input logic [3:0] mask,
                                       input logic [13:0] addr, input logic [31:0] data,
                                       input logic [2:0] y, input logic [1:0] x);
    return {op, mask, addr, data, y, x};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic send(input logic [PW-1:0] p);
    int n = 0;
    data_i = p;
    v_i    = 1'b1;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    check("send_ready", ready_o, 1'b1);
    tick();
    v_i = 1'b0;
  endtask

  task automatic model_store(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] mask);
    if (addr < 14'd1024)
      for (int b = 0; b < 4; b++)
        if (mask[b]) mdl[addr[9:0]][b*8 +: 8] = data[b*8 +: 8];
  endtask

  task automatic do_store(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] mask);
    model_store(addr, data, mask);
    send(mk(2'b01, mask, addr, data, 3'd0, 2'd0));
  endtask

  task automatic do_load(input logic [13:0] addr, input logic [2:0] y, input logic [1:0] x);
    if (addr < 14'd1024)
      exp_q.push_back(mk(2'b01, 4'hF, addr, mdl[addr[9:0]], y, x));
    send(mk(2'b10, 4'h0, addr, {27'd0, y, x}, 3'd0, 2'd0));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || v_o) && n < 200) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  logic [PW-1:0] prev_data;
  logic          prev_hold = 1'b0;

  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("reply_hold", data_o, prev_data);
      if (v_o && ready_i) begin
        if (exp_q.size() == 0) check("spurious_reply", v_o, 1'b0);
        else check("reply", data_o, exp_q.pop_front());
      end
      prev_hold = v_o && !ready_i;
      prev_data = data_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    data_i    = '0;
    ready_i   = 1'b1;
    repeat (3) tick();
    reset_n_i = 1'b1;
    tick();
    check("rst_ready", ready_o, 1'b1);
    check("rst_v", v_o, 1'b0);
    check("rst_data", data_o, '0);
    check("rst_counts", {store_count_o, load_count_o[15:0], drop_count_o}, '0);

    // store then load, with load-to-reply latency
    do_store(14'd5, 32'hDEADBEEF, 4'hF);
    do_load(14'd5, 3'd4, 2'd1);
    check("t1_v_early", v_o, 1'b0);
    tick();
    check("t1_v_rise", v_o, 1'b1);
    drain();
    check("t1_store_cnt", store_count_o, 32'd1);
    check("t1_load_cnt", load_count_o, 32'd1);

    // byte-masked overwrite
    do_store(14'd7, 32'h11223344, 4'hF);
    do_store(14'd7, 32'hAABBCCDD, 4'b0101);
    do_load(14'd7, 3'd0, 2'd2);
    drain();
    check("t2_model", mdl[7], 32'h11BB33DD);

    // backpressure on the reply while stores queue up
    ready_i = 1'b0;
    do_load(14'd7, 3'd2, 2'd3);
    do_store(14'd10, 32'h0000AAAA, 4'hF);
    do_store(14'd11, 32'h0000BBBB, 4'hF);
    check("t3_full", ready_o, 1'b0);
    model_store(14'd12, 32'h0000CCCC, 4'hF);
    data_i = mk(2'b01, 4'hF, 14'd12, 32'h0000CCCC, 3'd0, 2'd0);
    v_i    = 1'b1;
    repeat (8) tick();
    check("t3_still_full", ready_o, 1'b0);
    check("t3_v_held", v_o, 1'b1);
    check("t3_no_store", store_count_o, 32'd3);
    ready_i = 1'b1;
    tick();
    check("t3_drain0", store_count_o, 32'd3);
    tick();
    check("t3_drain1", store_count_o, 32'd4);
    check("t3_ready_back", ready_o, 1'b1);
    tick();
    v_i = 1'b0;
    check("t3_drain2", store_count_o, 32'd5);
    tick();
    check("t3_drain3", store_count_o, 32'd6);
    drain();
    do_load(14'd12, 3'd1, 2'd0);
    drain();

    // drops: out-of-range load, invalid opcode aimed at a live address
    do_load(14'd1024, 3'd1, 2'd1);
    send(mk(2'b11, 4'hF, 14'd7, 32'hFFFFFFFF, 3'd0, 2'd0));
    drain();
    check("t4_drops", drop_count_o, 16'd2);
    check("t4_loads", load_count_o, 32'd4);
    do_load(14'd7, 3'd3, 2'd3);
    drain();

    // reset during RESP
    ready_i = 1'b0;
    do_load(14'd5, 3'd1, 2'd2);
    tick();
    check("t5_v_before", v_o, 1'b1);
    reset_n_i = 1'b0;
    #1;
    check("t5_v_async", v_o, 1'b0);
    check("t5_data_async", data_o, '0);
    exp_q.delete();
    tick();
    tick();
    reset_n_i = 1'b1;
    ready_i   = 1'b1;
    tick();
    check("t5_ready", ready_o, 1'b1);
    check("t5_store_cnt", store_count_o, 32'd0);
    check("t5_load_cnt", load_count_o, 32'd0);
    check("t5_drop_cnt", drop_count_o, 16'd0);

    // counter saturation via preload
    force dut.store_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.store_cnt;
    tick();
    check("t6_preload", store_count_o, 32'hFFFF_FFFD);
    for (int i = 0; i < 5; i++)
      do_store(14'd20 + 14'(i), 32'h100 + 32'(i), 4'hF);
    drain();
    check("t6_saturate", store_count_o, 32'hFFFF_FFFF);
    do_load(14'd22, 3'd2, 2'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
